// File: rtl/bp_pkg.sv
// Shared opcode constants, counter type and call/return classification for the
// two-level branch predictor.
package bp_pkg;

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  typedef logic [1:0] cnt2_t;

  localparam cnt2_t CNT_SNT = 2'b00;
  localparam cnt2_t CNT_WNT = 2'b01;
  localparam cnt2_t CNT_ST  = 2'b11;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic logic is_ctrl(input logic [4:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  function automatic logic is_call(input logic [4:0] op, input logic [4:0] rd);
    return ((op == OP_JAL) || (op == OP_JALR)) && is_link(rd);
  endfunction

  function automatic logic is_ret(input logic [4:0] op, input logic [4:0] rd,
                                  input logic [4:0] rs1);
    return (op == OP_JALR) && is_link(rs1) && (rd == 5'd0);
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return address stack, updated only from resolved instructions.
// A push onto a full stack overwrites the oldest entry; a pop when empty is ignored.
module bp_ras #(
  parameter int unsigned Depth = 4,
  parameter int unsigned PcW   = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           push_i,
  input  logic           pop_i,
  input  logic [PcW-1:0] data_i,
  output logic [PcW-1:0] top_o,
  output logic           empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] PtrMax = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] CntMax = CntW'(Depth);

  logic [PcW-1:0]  stack_q [Depth];
  logic [PtrW-1:0] ptr_q, ptr_d, top_idx, wr_idx;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_en;

  // ptr_q names the next free slot; the top sits one below it (with wrap).
  assign top_idx = (ptr_q == '0) ? PtrMax : ptr_q - PtrW'(1);
  assign top_o   = stack_q[top_idx];
  assign empty_o = (cnt_q == '0);

  // Next pointer/count and which slot (if any) gets written.
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push_i && pop_i && (cnt_q != '0)) begin
      // Call-and-return: replace the top in place.
      wr_en  = 1'b1;
      wr_idx = top_idx;
    end else if (push_i) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
      ptr_d  = (ptr_q == PtrMax) ? '0 : ptr_q + PtrW'(1);
      if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = top_idx;
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Stack storage; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (wr_en) stack_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/branch_predictor_2lvl.sv
// Two-level local-history branch predictor with a tagged BTB.
// Predicts the fetch PC combinationally, detects mispredicts at resolve and
// trains the tables from resolved control-flow instructions.
// Optional feature: define BP_RAS_EN to build a non-speculative return address stack.
module branch_predictor_2lvl
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W     = 8,
  parameter int unsigned HIST_W    = 8,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [PC_W-1:0] f_pc_i,
  input  logic [4:0]      f_opcode_i,
  input  logic [4:0]      f_rd_i,
  input  logic [4:0]      f_rs1_i,
  input  logic [PC_W-1:0] f_pc_four_i,
  output logic            f_pred_taken_o,
  output logic [PC_W-1:0] f_pred_target_o,
  input  logic            r_valid_i,
  input  logic [PC_W-1:0] r_pc_i,
  input  logic [4:0]      r_opcode_i,
  input  logic [4:0]      r_rd_i,
  input  logic [4:0]      r_rs1_i,
  input  logic            r_taken_i,
  input  logic [PC_W-1:0] r_target_i,
  input  logic [PC_W-1:0] r_pc_four_i,
  input  logic            r_pred_taken_i,
  input  logic [PC_W-1:0] r_pred_target_i,
  output logic            flush_o,
  output logic [PC_W-1:0] nxt_pc_o
);

  localparam int unsigned NIdx = 2 ** IDX_W;
  localparam int unsigned NPht = 2 ** HIST_W;
  localparam int unsigned TagW = PC_W - IDX_W - 2;

  logic [NIdx-1:0]   btb_valid_q;
  logic [TagW-1:0]   btb_tag_q [NIdx];
  logic [PC_W-3:0]   btb_tgt_q [NIdx];
  logic [HIST_W-1:0] lht_q     [NIdx];
  cnt2_t             pht_q     [NPht];

  logic [IDX_W-1:0]  f_idx, r_idx;
  logic              f_hit, f_taken, f_use_ras;
  cnt2_t             f_cnt, r_cnt, r_cnt_nxt;
  logic [HIST_W-1:0] r_hist;
  logic [PC_W-1:0]   ras_top;
  logic              r_upd, r_is_br;

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  assign f_idx = f_pc_i[IDX_W+1:2];
  assign f_hit = btb_valid_q[f_idx] && (btb_tag_q[f_idx] == f_pc_i[PC_W-1:IDX_W+2]);
  assign f_cnt = pht_q[lht_q[f_idx]];

  // Direction and target for the fetch instruction; RAS overrides for returns.
  always_comb begin
    f_taken = 1'b0;
    unique case (f_opcode_i)
      OP_BRANCH:       f_taken = f_hit && f_cnt[1];
      OP_JAL, OP_JALR: f_taken = f_hit;
      default:         f_taken = 1'b0;
    endcase
    f_pred_taken_o  = f_taken || f_use_ras;
    f_pred_target_o = f_pc_four_i;
    if (f_use_ras)    f_pred_target_o = ras_top;
    else if (f_taken) f_pred_target_o = {btb_tgt_q[f_idx], 2'b00};
  end

  // ---------------------------------------------------------------------------
  // Resolve: mispredict detection and redirect
  // ---------------------------------------------------------------------------
  assign r_upd   = r_valid_i && is_ctrl(r_opcode_i);
  assign r_is_br = r_opcode_i == OP_BRANCH;

  // Flush on wrong direction, or on right-but-taken with a wrong target.
  always_comb begin
    flush_o  = r_upd && ((r_pred_taken_i != r_taken_i) ||
                         (r_taken_i && (r_pred_target_i != r_target_i)));
    nxt_pc_o = f_pred_target_o;
    if (flush_o) nxt_pc_o = r_taken_i ? r_target_i : r_pc_four_i;
  end

  // ---------------------------------------------------------------------------
  // Training
  // ---------------------------------------------------------------------------
  assign r_idx  = r_pc_i[IDX_W+1:2];
  assign r_hist = lht_q[r_idx];
  assign r_cnt  = pht_q[r_hist];

  // Saturating 2-bit counter step.
  always_comb begin
    r_cnt_nxt = r_cnt;
    if (r_taken_i) begin
      if (r_cnt != CNT_ST) r_cnt_nxt = r_cnt + 2'd1;
    end else if (r_cnt != CNT_SNT) begin
      r_cnt_nxt = r_cnt - 2'd1;
    end
  end

  // Reset-cleared predictor state: BTB valid bits, local histories, PHT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      btb_valid_q <= '0;
      for (int i = 0; i < int'(NIdx); i++) lht_q[i] <= '0;
      for (int i = 0; i < int'(NPht); i++) pht_q[i] <= CNT_WNT;
    end else if (r_upd) begin
      if (r_taken_i) btb_valid_q[r_idx] <= 1'b1;
      if (r_is_br) begin
        pht_q[r_hist] <= r_cnt_nxt;
        lht_q[r_idx]  <= {r_hist[HIST_W-2:0], r_taken_i};
      end
    end
  end

  // BTB tag/target payload, qualified by the valid bits above.
  always_ff @(posedge clk_i) begin
    if (r_upd && r_taken_i) begin
      btb_tag_q[r_idx] <= r_pc_i[PC_W-1:IDX_W+2];
      btb_tgt_q[r_idx] <= r_target_i[PC_W-1:2];
    end
  end

  // ---------------------------------------------------------------------------
  // Return address stack
  // ---------------------------------------------------------------------------
`ifdef BP_RAS_EN
  logic ras_push, ras_pop, ras_empty;

  assign ras_push  = r_upd && is_call(r_opcode_i, r_rd_i);
  assign ras_pop   = r_upd && is_ret(r_opcode_i, r_rd_i, r_rs1_i);
  assign f_use_ras = is_ret(f_opcode_i, f_rd_i, f_rs1_i) && !ras_empty;

  bp_ras #(
    .Depth(RAS_DEPTH),
    .PcW  (PC_W)
  ) u_ras (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (ras_push),
    .pop_i  (ras_pop),
    .data_i (r_pc_four_i),
    .top_o  (ras_top),
    .empty_o(ras_empty)
  );
`else
  logic unused_ras;

  assign f_use_ras  = 1'b0;
  assign ras_top    = '0;
  assign unused_ras = ^{f_rd_i, f_rs1_i, r_rd_i, r_rs1_i};
`endif

  // Byte-offset bits of the PCs never select anything.
  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{f_pc_i[1:0], r_pc_i[1:0]};

endmodule

// File: tb/tb_branch_predictor_2lvl.sv
// Self-checking bench for branch_predictor_2lvl: directed scenarios plus random
// traffic compared against a behavioural table model.
module tb_branch_predictor_2lvl;

  localparam int IW = 8;
  localparam int HW = 8;
  localparam int RD = 4;
  localparam int NI = 1 << IW;
  localparam int NH = 1 << HW;

  localparam logic [4:0] T_BR   = 5'b11000;
  localparam logic [4:0] T_JAL  = 5'b11011;
  localparam logic [4:0] T_JALR = 5'b11001;
  localparam logic [4:0] T_ALU  = 5'b00100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] f_pc, f_pc4, r_pc, r_tg, r_pc4, r_ptg;
  logic [4:0]  f_op, f_rd, f_rs1, r_op, r_rd, r_rs1;
  logic        r_valid, r_tk, r_ptk;
  logic        f_pred_taken_o, flush_o;
  logic [31:0] f_pred_target_o, nxt_pc_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  bit          m_val [NI];
  logic [31:0] m_tag [NI];
  logic [31:0] m_tgt [NI];
  int          m_lht [NI];
  int          m_pht [NH];
  logic [31:0] m_ras [$];

  branch_predictor_2lvl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .f_pc_i         (f_pc),
    .f_opcode_i     (f_op),
    .f_rd_i         (f_rd),
    .f_rs1_i        (f_rs1),
    .f_pc_four_i    (f_pc4),
    .f_pred_taken_o (f_pred_taken_o),
    .f_pred_target_o(f_pred_target_o),
    .r_valid_i      (r_valid),
    .r_pc_i         (r_pc),
    .r_opcode_i     (r_op),
    .r_rd_i         (r_rd),
    .r_rs1_i        (r_rs1),
    .r_taken_i      (r_tk),
    .r_target_i     (r_tg),
    .r_pc_four_i    (r_pc4),
    .r_pred_taken_i (r_ptk),
    .r_pred_target_i(r_ptg),
    .flush_o        (flush_o),
    .nxt_pc_o       (nxt_pc_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic bit ctrl(input logic [4:0] op);
    return (op == T_BR) || (op == T_JAL) || (op == T_JALR);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NI; i++) begin
      m_val[i] = 0;
      m_lht[i] = 0;
    end
    for (int i = 0; i < NH; i++) m_pht[i] = 1;
    m_ras.delete();
  endfunction

  function automatic void m_predict(input logic [31:0] pc, input logic [4:0] op,
                                    input logic [4:0] rd, input logic [4:0] rs1,
                                    output bit tk, output logic [31:0] tg);
    int idx;
    bit hit;
    idx = int'(pc[IW+1:2]);
    hit = m_val[idx] && (m_tag[idx] == (pc >> (IW + 2)));
    tk  = 0;
    if (op == T_BR) tk = hit && (m_pht[m_lht[idx]] >= 2);
    else if (op == T_JAL || op == T_JALR) tk = hit;
    tg = tk ? m_tgt[idx] : pc + 32'd4;
`ifdef BP_RAS_EN
    if (op == T_JALR && rd == 5'd0 && link(rs1) && m_ras.size() > 0) begin
      tk = 1;
      tg = m_ras[m_ras.size() - 1];
    end
`else
    if (rd == rs1) tk = tk;  // fields only matter with a RAS
`endif
  endfunction

  function automatic void m_update();
    int idx, h;
    bit call, ret;
    if (!(r_valid && ctrl(r_op))) return;
    idx = int'(r_pc[IW+1:2]);
    if (r_tk) begin
      m_val[idx] = 1;
      m_tag[idx] = r_pc >> (IW + 2);
      m_tgt[idx] = r_tg & ~32'd3;
    end
    if (r_op == T_BR) begin
      h = m_lht[idx];
      if (r_tk) m_pht[h] = (m_pht[h] < 3) ? m_pht[h] + 1 : 3;
      else      m_pht[h] = (m_pht[h] > 0) ? m_pht[h] - 1 : 0;
      m_lht[idx] = ((h << 1) | int'(r_tk)) % NH;
    end
    call = (r_op == T_JAL || r_op == T_JALR) && link(r_rd);
    ret  = (r_op == T_JALR) && link(r_rs1) && (r_rd == 5'd0);
`ifdef BP_RAS_EN
    if (call && ret && m_ras.size() > 0) m_ras[m_ras.size() - 1] = r_pc4;
    else if (call) begin
      m_ras.push_back(r_pc4);
      if (m_ras.size() > RD) void'(m_ras.pop_front());
    end else if (ret && m_ras.size() > 0) void'(m_ras.pop_back());
`else
    if (call && ret) m_ras.delete();
`endif
  endfunction

  task automatic set_fetch(input logic [31:0] pc, input logic [4:0] op,
                           input logic [4:0] rd, input logic [4:0] rs1);
    f_pc = pc; f_op = op; f_rd = rd; f_rs1 = rs1; f_pc4 = pc + 32'd4;
  endtask

  task automatic set_res(input logic v, input logic [31:0] pc, input logic [4:0] op,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic tk,
                         input logic [31:0] tg, input logic ptk, input logic [31:0] ptg);
    r_valid = v; r_pc = pc; r_op = op; r_rd = rd; r_rs1 = rs1;
    r_tk = tk; r_tg = tg; r_pc4 = pc + 32'd4; r_ptk = ptk; r_ptg = ptg;
  endtask

  task automatic res_idle();
    set_res(1'b0, 32'h0, T_ALU, 5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Resolve carrying the model's prediction for that PC, as the pipeline would.
  task automatic res_pred(input logic [31:0] pc, input logic [4:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic tk, input logic [31:0] tg);
    bit ptk;
    logic [31:0] ptg;
    m_predict(pc, op, rd, rs1, ptk, ptg);
    set_res(1'b1, pc, op, rd, rs1, tk, tg, ptk, ptg);
  endtask

  // Check all outputs against the model, then clock and advance the model.
  task automatic cycle(input string tag);
    bit etk, efl;
    logic [31:0] etg, enx;
    #2;
    m_predict(f_pc, f_op, f_rd, f_rs1, etk, etg);
    efl = r_valid && ctrl(r_op) && ((r_ptk != r_tk) || (r_tk && (r_ptg != r_tg)));
    enx = efl ? (r_tk ? r_tg : r_pc4) : etg;
    check({tag, ".taken"}, {31'd0, f_pred_taken_o}, {31'd0, etk});
    check({tag, ".target"}, f_pred_target_o, etg);
    check({tag, ".flush"}, {31'd0, flush_o}, {31'd0, efl});
    check({tag, ".nxt"}, nxt_pc_o, enx);
    @(posedge clk);
    m_update();
    #1;
  endtask

  logic [31:0] pool [8] = '{32'h100, 32'h104, 32'h500, 32'h200, 32'h400, 32'h2000,
                           32'h1100, 32'h80};
  logic [4:0]  ops  [4] = '{T_BR, T_JAL, T_JALR, T_ALU};
  logic [4:0]  regs [4] = '{5'd0, 5'd1, 5'd5, 5'd2};

  initial begin
    m_reset();
    set_fetch(32'h100, T_BR, 5'd0, 5'd0);
    res_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    #2;
    check("rst_taken", {31'd0, f_pred_taken_o}, 32'd0);
    check("rst_nxt", nxt_pc_o, 32'h104);
    check("rst_flush", {31'd0, flush_o}, 32'd0);
    cycle("rst");

    // First taken resolve mispredicts and redirects.
    set_res(1'b1, 32'h100, T_BR, 5'd0, 5'd0, 1'b1, 32'h80, 1'b0, 32'h104);
    #2;
    check("mp_flush", {31'd0, flush_o}, 32'd1);
    check("mp_nxt", nxt_pc_o, 32'h80);
    cycle("mp");

    // History 1 selects a fresh weakly-not-taken counter.
    res_idle();
    #2;
    check("fresh_taken", {31'd0, f_pred_taken_o}, 32'd0);
    cycle("fresh");

    // Saturate the history with taken outcomes.
    for (int i = 0; i < 9; i++) begin
      res_pred(32'h100, T_BR, 5'd0, 5'd0, 1'b1, 32'h80);
      cycle("train");
    end
    res_pred(32'h100, T_BR, 5'd0, 5'd0, 1'b1, 32'h80);
    #2;
    check("sat_taken", {31'd0, f_pred_taken_o}, 32'd1);
    check("sat_target", f_pred_target_o, 32'h80);
    check("sat_flush", {31'd0, flush_o}, 32'd0);
    cycle("sat");

    // Alternating pattern: flush-free once the two history patterns are trained.
    for (int i = 0; i < 20; i++) begin
      res_pred(32'h100, T_BR, 5'd0, 5'd0, i[0], i[0] ? 32'h80 : 32'h104);
      #2;
      if (i >= 10) check("alt_flush", {31'd0, flush_o}, 32'd0);
      cycle("alt");
    end

    // Aliasing PC shares the index but not the tag.
    res_idle();
    set_fetch(32'h500, T_BR, 5'd0, 5'd0);
    #2;
    check("alias_taken", {31'd0, f_pred_taken_o}, 32'd0);
    check("alias_target", f_pred_target_o, 32'h504);
    cycle("alias");

`ifdef BP_RAS_EN
    // Call then return predicted from the RAS.
    res_pred(32'h200, T_JAL, 5'd1, 5'd0, 1'b1, 32'h400);
    set_fetch(32'h600, T_ALU, 5'd0, 5'd0);
    cycle("call");
    res_idle();
    set_fetch(32'h400, T_JALR, 5'd0, 5'd1);
    #2;
    check("ret_taken", {31'd0, f_pred_taken_o}, 32'd1);
    check("ret_target", f_pred_target_o, 32'h204);
    cycle("ret_f");
    res_pred(32'h400, T_JALR, 5'd0, 5'd1, 1'b1, 32'h204);
    #2;
    check("ret_flush", {31'd0, flush_o}, 32'd0);
    cycle("ret_r");

    // Five pushes into four entries; pops return newest-first, oldest lost.
    set_fetch(32'h600, T_ALU, 5'd0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      res_pred(32'h1000 + 32'(i * 16), T_JAL, 5'd1, 5'd0, 1'b1, 32'h3000);
      cycle("push");
    end
    for (int i = 4; i >= 1; i--) begin
      res_idle();
      set_fetch(32'h2000, T_JALR, 5'd0, 5'd5);
      #2;
      check("pop_target", f_pred_target_o, 32'h1004 + 32'(i * 16));
      cycle("pop_f");
      res_pred(32'h2000, T_JALR, 5'd0, 5'd5, 1'b1, 32'h1004 + 32'(i * 16));
      cycle("pop_r");
    end
    res_idle();
    #2;
    check("empty_target", f_pred_target_o, 32'h1014);
    cycle("empty");
`endif

    // Reset between resolve and refetch clears the BTB.
    res_pred(32'h300, T_JAL, 5'd0, 5'd0, 1'b1, 32'h600);
    set_fetch(32'h700, T_ALU, 5'd0, 5'd0);
    cycle("alloc");
    res_idle();
    set_fetch(32'h300, T_JAL, 5'd0, 5'd0);
    #2;
    check("pre_rst_taken", {31'd0, f_pred_taken_o}, 32'd1);
    rst = 1'b1;
    #1;
    m_reset();
    check("mid_rst_taken", {31'd0, f_pred_taken_o}, 32'd0);
    check("mid_rst_nxt", nxt_pc_o, 32'h304);
    @(posedge clk);
    #1 rst = 1'b0;
    #2;
    check("post_rst_taken", {31'd0, f_pred_taken_o}, 32'd0);
    cycle("post_rst");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc;
      logic [4:0]  rop;
      set_fetch(pool[$urandom_range(7)], ops[$urandom_range(3)], regs[$urandom_range(3)],
                regs[$urandom_range(3)]);
      rpc = pool[$urandom_range(7)];
      rop = ops[$urandom_range(3)];
      if ($urandom_range(1) == 1) begin
        res_pred(rpc, rop, regs[$urandom_range(3)], regs[$urandom_range(3)],
                 (rop == T_JAL || rop == T_JALR) ? 1'b1 : 1'(($urandom_range(1))),
                 pool[$urandom_range(7)]);
      end else begin
        set_res(1'($urandom_range(3) != 0), rpc, rop, regs[$urandom_range(3)],
                regs[$urandom_range(3)],
                (rop == T_JAL || rop == T_JALR) ? 1'b1 : 1'(($urandom_range(1))),
                pool[$urandom_range(7)], 1'(($urandom_range(1))), pool[$urandom_range(7)]);
      end
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
